cv32e40s_pc_check_ext: RTL and testbench

Parametrised PC hardening checker and the successor to the single-cycle PC checker. It snapshots the selected control-flow target on every pc_set and holds a pending check until IF presents a valid PC, so stalled fetches are covered. It also checks sequential PCs, counts errors, and escalates to a sticky major alert. It sits beside the IF/ID stages and feeds the alert logic.

---
 rtl/cv32e40s_pc_check_ext.sv | 141 ++++++++++++++
 tb/tb_cv32e40s_pc_check_ext.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40s_pc_check_ext.sv
// PC hardening checker: snapshots control-flow targets on pc_set, verifies the next valid IF PC,
// checks sequential PCs, counts errors and escalates to a sticky major alert.
//
// state | meaning
// IDLE  | no target check outstanding; sequential check active
// PEND  | target captured in tgt_q, waiting for IF to present a valid PC
module cv32e40s_pc_check_ext #(
    parameter int NUM_TARGETS   = 12,
    parameter int SEL_W         = $clog2(NUM_TARGETS),
    parameter int ERR_CNT_W     = 4,
    parameter int ERR_THRESHOLD = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pc_set_i,
    input  logic [SEL_W-1:0]          pc_sel_i,
    input  logic [32*NUM_TARGETS-1:0] target_addr_i,
    input  logic [NUM_TARGETS-1:0]    target_excl_i,
    input  logic                      if_valid_i,
    input  logic                      id_ready_i,
    input  logic                      if_is_ptr_i,
    input  logic [31:0]               pc_if_i,
    input  logic [31:0]               if_id_pc_i,
    input  logic [1:0]                if_id_incr_i,
    output logic                      pc_err_o,
    output logic [ERR_CNT_W-1:0]      err_cnt_o,
    output logic                      alert_major_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    localparam logic [SEL_W:0]     NUM_TGT_W = (SEL_W+1)'(NUM_TARGETS);
    localparam logic [ERR_CNT_W:0] THRESH_W  = (ERR_CNT_W+1)'(ERR_THRESHOLD);

    state_e                 state_q, state_d;
    logic                   enable_q, enable_d;
    logic                   seq_q, seq_d;
    logic [31:0]            tgt_q, tgt_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   alert_q, alert_d;

    logic [31:0]            sel_target;
    logic                   sel_excl;
    logic                   sel_in_range;
    logic                   trigger;
    logic [31:0]            incr_amt;
    logic                   incr_bad;
    logic [31:0]            seq_exp;
    logic                   tgt_err;
    logic                   seq_err;
    logic                   pc_err;
    logic [ERR_CNT_W:0]     cnt_inc;

    always_comb begin
        sel_target = '0;
        sel_excl   = 1'b0;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            if (pc_sel_i == SEL_W'(k)) begin
                sel_target = target_addr_i[32*k +: 32];
                sel_excl   = target_excl_i[k];
            end
        end
    end

    assign sel_in_range = ({1'b0, pc_sel_i} < NUM_TGT_W);
    assign trigger      = pc_set_i & sel_in_range & ~sel_excl;

    always_comb begin
        incr_amt = '0;
        incr_bad = 1'b0;
        case (if_id_incr_i)
            2'd0:    incr_amt = 32'd0;
            2'd1:    incr_amt = 32'd2;
            2'd2:    incr_amt = 32'd4;
            default: incr_bad = 1'b1;
        endcase
    end

    // 32-bit add wraps naturally, so 0xFFFF_FFFE + 2 expects 0
    assign seq_exp = if_id_pc_i + incr_amt;

    assign tgt_err = (state_q == PEND) & if_valid_i & (pc_if_i != tgt_q);
    assign seq_err = seq_q & (state_q == IDLE) & (incr_bad | (pc_if_i != seq_exp));
    assign pc_err  = enable_q & (tgt_err | seq_err);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        if (trigger) begin
            // a same-cycle compare has already used the old tgt_q above
            state_d = PEND;
            tgt_d   = sel_target & 32'hFFFF_FFFE;
        end else if (pc_set_i) begin
            state_d = IDLE;
        end else if ((state_q == PEND) && if_valid_i) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        enable_d = enable_q | pc_set_i;
        seq_d    = if_valid_i & id_ready_i & ~if_is_ptr_i & ~pc_set_i;
        cnt_inc  = {1'b0, cnt_q} + (ERR_CNT_W+1)'(1);
        cnt_d    = cnt_q;
        alert_d  = alert_q;
        if (pc_err) begin
            if (!(&cnt_q)) begin
                cnt_d = cnt_inc[ERR_CNT_W-1:0];
            end
            if (cnt_inc >= THRESH_W) begin
                alert_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            seq_q    <= 1'b0;
            tgt_q    <= '0;
            cnt_q    <= '0;
            alert_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            seq_q    <= seq_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            alert_q  <= alert_d;
        end
    end

    assign pc_err_o      = pc_err;
    assign err_cnt_o     = cnt_q;
    assign alert_major_o = alert_q;

endmodule

// File: tb/tb_cv32e40s_pc_check_ext.sv
// Bench for cv32e40s_pc_check_ext: directed scenarios plus random traffic against a behavioural model.
// Two instances share stimulus: default parameters and a 2-bit error counter for saturation.
module tb_cv32e40s_pc_check_ext;

    localparam int NT = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pc_set;
    logic [3:0]        pc_sel;
    logic [32*NT-1:0]  target_flat;
    logic [NT-1:0]     excl;
    logic              if_valid, id_ready, is_ptr;
    logic [31:0]       pc_if, if_id_pc;
    logic [1:0]        incr;

    logic              pc_err_a, alert_a;
    logic [3:0]        cnt_a;
    logic              pc_err_b, alert_b;
    logic [1:0]        cnt_b;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    bit          m_en;
    int unsigned m_pend[$];
    bit          m_xfer;
    int          m_cnt_a, m_cnt_b;
    bit          m_al_a, m_al_b;
    bit          e_err;

    always #5 clk = ~clk;

    cv32e40s_pc_check_ext #(.NUM_TARGETS(NT), .ERR_CNT_W(4), .ERR_THRESHOLD(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .pc_set_i(pc_set), .pc_sel_i(pc_sel),
        .target_addr_i(target_flat), .target_excl_i(excl), .if_valid_i(if_valid),
        .id_ready_i(id_ready), .if_is_ptr_i(is_ptr), .pc_if_i(pc_if),
        .if_id_pc_i(if_id_pc), .if_id_incr_i(incr), .pc_err_o(pc_err_a),
        .err_cnt_o(cnt_a), .alert_major_o(alert_a)
    );

    cv32e40s_pc_check_ext #(.NUM_TARGETS(NT), .ERR_CNT_W(2), .ERR_THRESHOLD(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .pc_set_i(pc_set), .pc_sel_i(pc_sel),
        .target_addr_i(target_flat), .target_excl_i(excl), .if_valid_i(if_valid),
        .id_ready_i(id_ready), .if_is_ptr_i(is_ptr), .pc_if_i(pc_if),
        .if_id_pc_i(if_id_pc), .if_id_incr_i(incr), .pc_err_o(pc_err_b),
        .err_cnt_o(cnt_b), .alert_major_o(alert_b)
    );

    function automatic logic [9:0] obs();
        return {pc_err_a, cnt_a, alert_a, pc_err_b, cnt_b, alert_b};
    endfunction

    function automatic logic [9:0] expv();
        logic [3:0] ca;
        logic [1:0] cb;
        ca = m_cnt_a[3:0];
        cb = m_cnt_b[1:0];
        return {e_err, ca, m_al_a, e_err, cb, m_al_b};
    endfunction

    task automatic set_target(input int k, input logic [31:0] addr);
        target_flat[32*k +: 32] = addr;
    endtask

    task automatic model_clear();
        m_en = 0;
        m_pend.delete();
        m_xfer = 0;
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_al_a = 0;
        m_al_b = 0;
        e_err = 0;
    endtask

    // drive one cycle of inputs and derive the expected error from the model
    task automatic apply(input bit set, input int sel, input bit v, input bit rdy, input bit ptr,
                         input logic [31:0] pc, input logic [31:0] idpc, input logic [1:0] inc);
        bit tgt_e, seq_e;
        logic [31:0] want;
        pc_set   = set;
        pc_sel   = 4'(sel);
        if_valid = v;
        id_ready = rdy;
        is_ptr   = ptr;
        pc_if    = pc;
        if_id_pc = idpc;
        incr     = inc;
        #1;
        want  = idpc + 32'(inc) * 32'd2;
        tgt_e = (m_pend.size() > 0) && v && (pc != m_pend[0]);
        seq_e = m_xfer && (m_pend.size() == 0) && ((inc == 2'd3) || (pc != want));
        e_err = m_en && (tgt_e || seq_e);
    endtask

    task automatic tick();
        int s;
        bit trig;
        @(posedge clk);
        if (e_err) begin
            if (m_cnt_a + 1 >= 2) m_al_a = 1;
            if (m_cnt_b + 1 >= 2) m_al_b = 1;
            if (m_cnt_a < 15) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
        end
        s = int'(pc_sel);
        trig = pc_set && (s < NT) && !excl[s];
        if (trig) begin
            m_pend.delete();
            m_pend.push_back(target_flat[32*s +: 32] & 32'hFFFF_FFFE);
        end else if (pc_set) begin
            m_pend.delete();
        end else if ((m_pend.size() > 0) && if_valid) begin
            m_pend.delete();
        end
        m_xfer = if_valid && id_ready && !is_ptr && !pc_set;
        if (pc_set) m_en = 1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pc_set = 0; pc_sel = 0; if_valid = 0; id_ready = 0; is_ptr = 0;
        pc_if = 0; if_id_pc = 0; incr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        excl = '0;
        target_flat = '0;
        model_clear();
        @(negedge clk);
        n_cmp++;
        if ({pc_err_a, cnt_a, alert_a, cnt_b, alert_b} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000000", {pc_err_a, cnt_a, alert_a, cnt_b, alert_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_gating();
        apply(0, 0, 1, 1, 0, 32'h10, 32'h0, 2'd2); tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 1, 0, 32'h999 + 32'(i), 32'h200, 2'd2);
            n_cmp++;
            if (pc_err_a !== 1'b0 || obs() !== expv()) begin
                n_fail++;
                $display("FAIL gating: obs=%b exp=%b", obs(), expv());
            end
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic target_check(input string name, input logic [31:0] pc, input bit want_err);
        set_target(1, 32'h0000_2000);
        apply(1, 1, 0, 0, 0, 32'h2000, 0, 0);
        n_cmp++;
        if (pc_err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_trigger_cycle: pc_err=%b want 0", name, pc_err_a);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 32'hDEAD_0000, 0, 0);
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL %s_stall: obs=%b exp=%b", name, obs(), expv());
            end
            tick();
        end
        apply(0, 0, 1, 0, 0, pc, 0, 0);
        n_cmp++;
        if (pc_err_a !== want_err || obs() !== expv()) begin
            n_fail++;
            $display("FAIL %s_compare: pc_err=%b want %b obs=%b exp=%b", name, pc_err_a, want_err, obs(), expv());
        end
        tick();
        apply(0, 0, 1, 0, 0, 32'hBAD0, 0, 0);
        n_cmp++;
        if (pc_err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_back_to_idle: pc_err=%b want 0", name, pc_err_a);
        end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_jump_target();
        target_check("jump_ok", 32'h2000, 1'b0);
    endtask

    task automatic test_target_mismatch();
        target_check("jump_bad", 32'h2004, 1'b1);
        n_cmp++;
        if (cnt_a !== 4'd1 || alert_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch_count: cnt=%0d alert=%b want 1/0", cnt_a, alert_a);
        end
    endtask

    task automatic test_escalation();
        target_check("escalate", 32'h2008, 1'b1);
        n_cmp++;
        if (cnt_a !== 4'd2 || alert_a !== 1'b1) begin
            n_fail++;
            $display("FAIL escalate_alert: cnt=%0d alert=%b want 2/1", cnt_a, alert_a);
        end
        for (int i = 0; i < 100; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0); tick();
        end
        n_cmp++;
        if (alert_a !== 1'b1 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL alert_sticky: alert=%b want 1 obs=%b exp=%b", alert_a, obs(), expv());
        end
        do_reset();
        n_cmp++;
        if (alert_a !== 1'b0 || cnt_a !== 4'd0) begin
            n_fail++;
            $display("FAIL alert_reset: alert=%b cnt=%0d want 0/0", alert_a, cnt_a);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pcs [5]  = '{32'h104, 32'h104, 32'h0, 32'h50, 32'h777};
        logic [31:0] ids [5]  = '{32'h100, 32'h100, 32'hFFFF_FFFE, 32'h50, 32'h10};
        logic [1:0]  incs [5] = '{2'd2, 2'd1, 2'd1, 2'd3, 2'd2};
        bit          ptrs [5] = '{0, 0, 0, 1, 0};
        bit          want [5] = '{0, 1, 0, 1, 0};
        apply(1, 13, 0, 0, 0, 0, 0, 0); tick();
        apply(0, 0, 1, 1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 1, 1, ptrs[i], pcs[i], ids[i], incs[i]);
            n_cmp++;
            if (pc_err_a !== want[i] || obs() !== expv()) begin
                n_fail++;
                $display("FAIL sequential[%0d]: pc_err=%b want %b obs=%b exp=%b", i, pc_err_a, want[i], obs(), expv());
            end
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_exclusion();
        excl = '0;
        excl[5] = 1'b1;
        set_target(2, 32'h300);
        set_target(5, 32'h500);
        apply(1, 2, 0, 0, 0, 0, 0, 0); tick();
        apply(1, 5, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 1, 0, 0, $urandom, 0, 0);
            n_cmp++;
            if (pc_err_a !== 1'b0 || obs() !== expv()) begin
                n_fail++;
                $display("FAIL exclusion: pc_err=%b want 0 obs=%b exp=%b", pc_err_a, obs(), expv());
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] chk [2] = '{32'h80, 32'h40};
        for (int j = 0; j < 2; j++) begin
            set_target(3, 32'h40);
            set_target(4, 32'h81);
            apply(1, 3, 0, 0, 0, 0, 0, 0); tick();
            apply(1, 4, 0, 0, 0, 0, 0, 0); tick();
            apply(0, 0, 0, 0, 0, 0, 0, 0); tick();
            apply(0, 0, 1, 0, 0, chk[j], 0, 0);
            n_cmp++;
            if (pc_err_a !== 1'(j) || obs() !== expv()) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: pc_err=%b want %b obs=%b exp=%b", j, pc_err_a, 1'(j), obs(), expv());
            end
            tick();
        end
        // compare and retrigger in the same cycle: old target checked, new one pending
        set_target(6, 32'h600);
        set_target(7, 32'h700);
        apply(1, 6, 0, 0, 0, 0, 0, 0); tick();
        apply(1, 7, 1, 0, 0, 32'h604, 0, 0);
        n_cmp++;
        if (pc_err_a !== 1'b1 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL retrigger_old: pc_err=%b want 1 obs=%b exp=%b", pc_err_a, obs(), expv());
        end
        tick();
        apply(0, 0, 1, 0, 0, 32'h700, 0, 0);
        n_cmp++;
        if (pc_err_a !== 1'b0 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL retrigger_new: pc_err=%b want 0 obs=%b exp=%b", pc_err_a, obs(), expv());
        end
        tick();
    endtask

    task automatic test_reset_mid_pend();
        set_target(8, 32'h800);
        apply(1, 8, 0, 0, 0, 0, 0, 0); tick();
        rst_n = 1'b0;
        model_clear();
        #2;
        rst_n = 1'b1;
        apply(0, 0, 1, 0, 0, 32'h1234, 0, 0);
        n_cmp++;
        if (pc_err_a !== 1'b0 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL reset_mid_pend: pc_err=%b want 0 obs=%b exp=%b", pc_err_a, obs(), expv());
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        apply(1, 13, 0, 0, 0, 0, 0, 0); tick();
        apply(0, 0, 1, 1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 1, 1, 0, 32'h4, 32'h0, 2'd3);
            n_cmp++;
            if (pc_err_b !== 1'b1 || obs() !== expv()) begin
                n_fail++;
                $display("FAIL saturation_err[%0d]: obs=%b exp=%b", i, obs(), expv());
            end
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (cnt_b !== 2'd3 || cnt_a !== 4'd6 || alert_b !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation_count: cnt_b=%0d cnt_a=%0d alert_b=%b want 3/6/1", cnt_b, cnt_a, alert_b);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] pc, idpc;
        logic [1:0]  inc;
        int          choice;
        excl = NT'($urandom);
        for (int i = 0; i < 400; i++) begin
            set_target($urandom_range(0, NT - 1), $urandom);
            idpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
            inc    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            choice = $urandom_range(0, 3);
            if (choice == 0 && m_pend.size() > 0) pc = m_pend[0];
            else if (choice <= 2) pc = idpc + 32'(inc) * 32'd2;
            else pc = $urandom;
            apply($urandom_range(0, 5) == 0, $urandom_range(0, 13), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, pc, idpc, inc);
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL random[%0d]: obs=%b exp=%b", i, obs(), expv());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_gating();
        test_jump_target();
        test_target_mismatch();
        test_escalation();
        test_sequential();
        test_exclusion();
        test_back_to_back();
        test_reset_mid_pend();
        test_saturation();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
